// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: digit count, segment bit positions, hex font.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package seg_pkg;

  // Number of multiplexed digits; the scan index and enable vector are sized from this.
  localparam int DIGITS  = 4;
  localparam int IDX_W   = 2;
  localparam int DIGIT_W = 4;

  // Bit positions inside seven_seg = {dp,g,f,e,d,c,b,a}.
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Hex font, bits g..a, active high. Lower-case b and d keep them distinct from 8 and 0.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  // One-hot digit enable for a scan index.
  function automatic logic [DIGITS-1:0] digit_onehot(input logic [IDX_W-1:0] idx);
    digit_onehot = DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational 4-bit hex/BCD value to seven-segment pattern (g..a).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] hex_dat,
  output logic [6:0] seg_dat
);

  // Table lookup into the shared font.
  always_comb begin
    seg_dat = SEG_HEX[hex_dat];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit seven-segment scanner with dead time, PWM dimming and per-frame shadow latching.
// Latency: outputs registered, 1 cycle after the counter state that produced them.
// Backpressure: none; free-running scan, inputs sampled once per frame (brightness/disp_en live).
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DIGITS*DIGIT_W-1:0] digits_bcd,
  input  logic [DIGITS-1:0]         dp,
  input  logic [DIGITS-1:0]         blank_mask,
  input  logic [3:0]                brightness,
  input  logic                      disp_en,
  output logic [7:0]                seven_seg,
  output logic [DIGITS-1:0]         digit_en,
  output logic                      frame_tick
);

  localparam int SLOT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // Scan counters.
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        pwm_q, pwm_d;

  // Frame-stable copies of the display contents.
  logic [DIGITS*DIGIT_W-1:0] shadow_digit_q, shadow_digit_d;
  logic [DIGITS-1:0]         shadow_dp_q, shadow_dp_d;
  logic [DIGITS-1:0]         shadow_blank_q, shadow_blank_d;

  // Registered outputs.
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] en_q, en_d;
  logic              tick_q, tick_d;

  // Decode path for the digit currently being scanned.
  logic              slot_wrap;
  logic              frame_start;
  logic              lit;
  logic [3:0]        cur_digit;
  logic [6:0]        cur_glyph;

  seg_hex_decoder u_hex (
    .hex_dat (cur_digit),
    .seg_dat (cur_glyph)
  );

  // Counter advance: slot counter wraps per digit, index wraps per frame, PWM free-runs.
  always_comb begin
    slot_wrap = (slot_q == SLOT_W'(PRESCALE - 1));
    slot_d    = slot_wrap ? '0 : slot_q + 1'b1;
    idx_d     = idx_q;
    if (slot_wrap) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    pwm_d     = pwm_q + 4'd1;
  end

  // Shadow capture at the first cycle of each frame; the tick follows one cycle later.
  always_comb begin
    frame_start    = (idx_q == '0) && (slot_q == '0);
    shadow_digit_d = shadow_digit_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    if (frame_start) begin
      shadow_digit_d = digits_bcd;
      shadow_dp_d    = dp;
      shadow_blank_d = blank_mask;
    end
    tick_d = frame_start;
  end

  // Lit decision and next output values; the leading dead time hides the digit change.
  always_comb begin
    cur_digit = shadow_digit_q[{idx_q, 2'b00} +: DIGIT_W];
    lit       = (slot_q >= SLOT_W'(BLANK_CYCLES))
             && (pwm_q <= brightness)
             && disp_en
             && !shadow_blank_q[idx_q];
    en_d      = '0;
    seg_d     = '0;
    if (lit) begin
      en_d          = digit_onehot(idx_q);
      seg_d[6:0]    = cur_glyph;
      seg_d[SEG_DP] = shadow_dp_q[idx_q];
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q         <= '0;
      idx_q          <= '0;
      pwm_q          <= '0;
      shadow_digit_q <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      seg_q          <= '0;
      en_q           <= '0;
      tick_q         <= 1'b0;
    end else begin
      slot_q         <= slot_d;
      idx_q          <= idx_d;
      pwm_q          <= pwm_d;
      shadow_digit_q <= shadow_digit_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      seg_q          <= seg_d;
      en_q           <= en_d;
      tick_q         <= tick_d;
    end
  end

  assign seven_seg  = seg_q;
  assign digit_en   = en_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with PRESCALE=8, BLANK_CYCLES=2 (frame = 32 cycles).
// Latency: n/a.
// Backpressure: n/a.
module tb_seg_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits_bcd;
  logic [3:0]  dp;
  logic [3:0]  blank_mask;
  logic [3:0]  brightness;
  logic        disp_en;
  logic [7:0]  seven_seg;
  logic [3:0]  digit_en;
  logic        frame_tick;

  int errs;
  int checks;

  seg_scan_driver #(
    .PRESCALE     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digits_bcd (digits_bcd),
    .dp         (dp),
    .blank_mask (blank_mask),
    .brightness (brightness),
    .disp_en    (disp_en),
    .seven_seg  (seven_seg),
    .digit_en   (digit_en),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Hand-computed output snapshots, keyed by cycle index g (g=0 is the first cycle after reset).
  typedef struct {
    int         g;
    logic [3:0] en;
    logic [7:0] seg;
  } dvec_t;

  localparam int NDV = 34;
  dvec_t dv [NDV] = '{
    '{0,   4'h0, 8'h00}, '{3,   4'h1, 8'h3F}, '{8,   4'h1, 8'h3F}, '{9,   4'h0, 8'h00},
    '{10,  4'h0, 8'h00}, '{11,  4'h2, 8'h06}, '{16,  4'h2, 8'h06}, '{19,  4'h4, 8'h5B},
    '{24,  4'h4, 8'h5B}, '{27,  4'h8, 8'h4F}, '{32,  4'h8, 8'h4F}, '{35,  4'h1, 8'h7F},
    '{43,  4'h2, 8'h7F}, '{51,  4'h4, 8'h77}, '{59,  4'h8, 8'h71}, '{67,  4'h1, 8'hBF},
    '{72,  4'h1, 8'hBF}, '{75,  4'h0, 8'h00}, '{80,  4'h0, 8'h00}, '{83,  4'h4, 8'h5B},
    '{91,  4'h8, 8'h4F}, '{99,  4'h1, 8'h3F}, '{100, 4'h1, 8'h3F}, '{101, 4'h0, 8'h00},
    '{107, 4'h0, 8'h00}, '{115, 4'h4, 8'h5B}, '{116, 4'h4, 8'h5B}, '{117, 4'h0, 8'h00},
    '{131, 4'h0, 8'h00}, '{147, 4'h0, 8'h00}, '{163, 4'h1, 8'h3F}, '{181, 4'h0, 8'h00},
    '{184, 4'h1, 8'h3F}, '{192, 4'h2, 8'h06}
  };

  // Hand-computed frame_tick values at selected cycles.
  localparam int NTK = 13;
  int   tk_g   [NTK] = '{1, 33, 65, 97, 129, 161, 182, 214, 0, 2, 32, 181, 183};
  logic tk_val [NTK] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                         1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  // Cycle-level reference: counters and shadow copy tracked from the spec's description.
  int         m_slot;
  int         m_idx;
  int         m_pwm;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  logic [3:0]  exp_en;
  logic [7:0]  exp_seg;
  logic        exp_tick;

  task automatic model_step();
    logic       lit;
    logic [3:0] d;
    if (!rst_n) begin
      exp_en = '0; exp_seg = '0; exp_tick = 1'b0;
      m_slot = 0; m_idx = 0; m_pwm = 0;
      m_dig = '0; m_dp = '0; m_blank = '0;
    end else begin
      lit = (m_slot >= 2) && (m_pwm <= int'(brightness)) && disp_en && !m_blank[m_idx];
      d   = m_dig[m_idx*4 +: 4];
      exp_en   = lit ? (4'b0001 << m_idx) : 4'b0000;
      exp_seg  = lit ? {m_dp[m_idx], hex7(d)} : 8'h00;
      exp_tick = (m_slot == 0) && (m_idx == 0);
      if (exp_tick) begin
        m_dig = digits_bcd; m_dp = dp; m_blank = blank_mask;
      end
      m_pwm = (m_pwm + 1) % 16;
      if (m_slot == 7) begin
        m_slot = 0;
        m_idx  = (m_idx + 1) % 4;
      end else begin
        m_slot = m_slot + 1;
      end
    end
  endtask

  // Input changes, applied just after the edge that starts cycle g.
  task automatic apply_stim(input int g);
    case (g)
      12:  digits_bcd = 16'hFA88;
      40:  begin digits_bcd = 16'h3210; dp = 4'b0001; blank_mask = 4'b0010; end
      80:  begin dp = 4'b0000; blank_mask = 4'b0000; end
      96:  brightness = 4'd3;
      128: begin brightness = 4'd15; disp_en = 1'b0; end
      160: disp_en = 1'b1;
      180: rst_n = 1'b0;
      181: rst_n = 1'b1;
      default: ;
    endcase
  endtask

  initial begin
    errs       = 0;
    checks     = 0;
    rst_n      = 1'b0;
    digits_bcd = 16'h3210;
    dp         = 4'b0000;
    blank_mask = 4'b0000;
    brightness = 4'd15;
    disp_en    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_slot = 0; m_idx = 0; m_pwm = 0;
    m_dig = '0; m_dp = '0; m_blank = '0;
    exp_en = '0; exp_seg = '0; exp_tick = 1'b0;

    for (int g = 0; g <= 230; g++) begin
      check_eq($sformatf("en g=%0d", g), 32'(digit_en), 32'(exp_en));
      check_eq($sformatf("seg g=%0d", g), 32'(seven_seg), 32'(exp_seg));
      check_eq($sformatf("tick g=%0d", g), 32'(frame_tick), 32'(exp_tick));
      check_eq($sformatf("onehot g=%0d", g), 32'($countones(digit_en) <= 1), 32'd1);
      if (digit_en == 4'b0000) begin
        check_eq($sformatf("ghost g=%0d", g), 32'(seven_seg), 32'd0);
      end
      for (int k = 0; k < NDV; k++) begin
        if (dv[k].g == g) begin
          check_eq($sformatf("dir_en g=%0d", g), 32'(digit_en), 32'(dv[k].en));
          check_eq($sformatf("dir_seg g=%0d", g), 32'(seven_seg), 32'(dv[k].seg));
        end
      end
      for (int k = 0; k < NTK; k++) begin
        if (tk_g[k] == g) begin
          check_eq($sformatf("dir_tick g=%0d", g), 32'(frame_tick), 32'(tk_val[k]));
        end
      end
      apply_stim(g);
      model_step();
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
